// File: rtl/cpu_dump_pkg.sv
// Shared types and constants for the post-halt CPU state dumper.
package cpu_dump_pkg;

    // Width of the walk index and of the out_index field.
    localparam int DUMP_INDEX_W = 16;

    // Default sizes of the single-cycle MIPS register file and data memory.
    localparam int DEF_REG_COUNT = 32;
    localparam int DEF_MEM_DEPTH = 64;

    // Beat kind tag carried in the top payload bit.
    localparam logic KIND_REG = 1'b0;
    localparam logic KIND_MEM = 1'b1;

    // Payload layout: {kind, index, data}.
    localparam int DUMP_DATA_W    = 32;
    localparam int DUMP_PAYLOAD_W = 1 + DUMP_INDEX_W + DUMP_DATA_W;

    // Dump sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REGS = 2'd1,
        MEMS = 2'd2,
        DONE = 2'd3
    } dump_state_t;

endpackage

// File: rtl/cpu_state_dumper_out_buffer.sv
// One-entry valid/ready output register for the dump stream.
module dump_out_buffer
    import cpu_dump_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [DUMP_PAYLOAD_W-1:0] payload,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [DUMP_PAYLOAD_W-1:0] payload_q,
    output logic                      can_load
);

    logic                      valid_reg;
    logic [DUMP_PAYLOAD_W-1:0] payload_reg;

    // A new beat may enter when the slot is empty or is being drained now.
    assign can_load  = !valid_reg || out_ready;
    assign out_valid = valid_reg;
    assign payload_q = payload_reg;

    // Hold the beat until accepted; refill in the same cycle it drains.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg   <= 1'b0;
            payload_reg <= '0;
        end else if (load) begin
            valid_reg   <= 1'b1;
            payload_reg <= payload;
        end else if (out_ready) begin
            valid_reg   <= 1'b0;
        end
    end

endmodule

// File: rtl/cpu_state_dumper.sv
// Post-halt readout: freezes the CPU, then streams every register and
// every data-memory word over a valid/ready interface.
module cpu_state_dumper
    import cpu_dump_pkg::*;
#(
    parameter int REG_COUNT = DEF_REG_COUNT,
    parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    halt,
    output logic                    freeze,
    output logic [4:0]              reg_a,
    input  logic [31:0]             reg_rd,
    output logic [31:0]             mem_a,
    input  logic [31:0]             mem_rd,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_kind,
    output logic [DUMP_INDEX_W-1:0] out_index,
    output logic [31:0]             out_data,
    output logic                    done
);

    localparam logic [DUMP_INDEX_W-1:0] REG_LAST = DUMP_INDEX_W'(REG_COUNT - 1);
    localparam logic [DUMP_INDEX_W-1:0] MEM_LAST = DUMP_INDEX_W'(MEM_DEPTH - 1);

    dump_state_t               state_reg, state_next;
    logic [DUMP_INDEX_W-1:0]   index_reg, index_next;
    logic                      load;
    logic                      can_load;
    logic [DUMP_PAYLOAD_W-1:0] payload;
    logic [DUMP_PAYLOAD_W-1:0] payload_q;

    dump_out_buffer u_out_buffer (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .payload   (payload),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .payload_q (payload_q),
        .can_load  (can_load)
    );

    assign out_kind  = payload_q[DUMP_PAYLOAD_W-1];
    assign out_index = payload_q[DUMP_DATA_W +: DUMP_INDEX_W];
    assign out_data  = payload_q[DUMP_DATA_W-1:0];

    // Once halt is captured the CPU stays frozen until reset.
    assign freeze = (state_reg != IDLE);
    assign done   = (state_reg == DONE) && !out_valid;

    // State and walk index registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            index_reg <= '0;
        end else begin
            state_reg <= state_next;
            index_reg <= index_next;
        end
    end

    // Sequencer: drives read addresses, builds the beat, advances on load slots.
    always_comb begin
        state_next = state_reg;
        index_next = index_reg;
        load       = 1'b0;
        payload    = '0;
        reg_a      = '0;
        mem_a      = '0;
        case (state_reg)
            IDLE: begin
                if (halt) begin
                    state_next = REGS;
                    index_next = '0;
                end
            end
            REGS: begin
                reg_a   = index_reg[4:0];
                payload = {KIND_REG, index_reg, reg_rd};
                if (can_load) begin
                    load = 1'b1;
                    if (index_reg == REG_LAST) begin
                        state_next = MEMS;
                        index_next = '0;
                    end else begin
                        index_next = index_reg + 1'b1;
                    end
                end
            end
            MEMS: begin
                // Word-aligned byte address.
                mem_a   = {14'd0, index_reg, 2'b00};
                payload = {KIND_MEM, index_reg, mem_rd};
                if (can_load) begin
                    load = 1'b1;
                    if (index_reg == MEM_LAST) begin
                        state_next = DONE;
                    end else begin
                        index_next = index_reg + 1'b1;
                    end
                end
            end
            DONE: begin
                state_next = DONE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_state_dumper.sv
// Randomized self-checking bench for cpu_state_dumper with a simple
// register-file / data-memory model and an expected-beat queue.
module tb_cpu_state_dumper;

    localparam int NREG = 32;
    localparam int NMEM = 64;
    localparam int NBEATS = NREG + NMEM;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        halt = 1'b0;
    logic        freeze;
    logic [4:0]  reg_a;
    logic [31:0] reg_rd;
    logic [31:0] mem_a;
    logic [31:0] mem_rd;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_kind;
    logic [15:0] out_index;
    logic [31:0] out_data;
    logic        done;

    // CPU-side write port into the data memory, gated by freeze.
    logic        cpu_we = 1'b0;
    logic [5:0]  cpu_wa = '0;
    logic [31:0] cpu_wd = '0;

    logic [31:0] regs [NREG];
    logic [31:0] mem  [NMEM];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    assign reg_rd = regs[reg_a];
    assign mem_rd = mem[mem_a[7:2]];

    always @(posedge clk) begin
        if (cpu_we && !freeze) mem[cpu_wa] <= cpu_wd;
    end

    cpu_state_dumper #(.REG_COUNT(NREG), .MEM_DEPTH(NMEM)) dut (
        .clk       (clk),
        .reset     (reset),
        .halt      (halt),
        .freeze    (freeze),
        .reg_a     (reg_a),
        .reg_rd    (reg_rd),
        .mem_a     (mem_a),
        .mem_rd    (mem_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_kind  (out_kind),
        .out_index (out_index),
        .out_data  (out_data),
        .done      (done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_freeze"}, 64'(freeze), 64'd0);
        check({tag, "_valid"},  64'(out_valid), 64'd0);
        check({tag, "_done"},   64'(done), 64'd0);
        check({tag, "_payload"}, {15'd0, out_kind, out_index, out_data}, 64'd0);
        check({tag, "_addr"},   {27'd0, reg_a, mem_a}, 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        halt  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check_idle_outputs("reset");
    endtask

    // mode 0: ready always high, 1: toggling, 2: random.
    // stop_mem40: abandon the dump once memory beat 40 is presented.
    task automatic do_dump(input int mode, input bit stop_mem40);
        logic [63:0] exp_q[$];
        logic [63:0] beat, held;
        bit          stalled = 1'b0;
        int          beats = 0;
        int          cycles = 0;
        for (int i = 0; i < NREG; i++) exp_q.push_back({15'd0, 1'b0, 16'(i), regs[i]});
        for (int j = 0; j < NMEM; j++) exp_q.push_back({15'd0, 1'b1, 16'(j), mem[j]});
        // One-cycle halt pulse; it is latched by the dumper.
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        check("halt_freeze", 64'(freeze), 64'd1);
        check("halt_valid0", 64'(out_valid), 64'd0);
        out_ready = (mode == 0) ? 1'b1 : 1'b1;
        while (beats < NBEATS && cycles < 2000) begin
            @(negedge clk);
            cycles++;
            cpu_we = (cycles == 2);
            cpu_wa = 6'd5;
            cpu_wd = 32'hDEAD_BEEF;
            beat = {15'd0, out_kind, out_index, out_data};
            if (stalled) check("stall_hold", beat, held);
            check("freeze_hi", 64'(freeze), 64'd1);
            check("done_early", 64'(done), 64'd0);
            if (mode == 0) check("contig_valid", 64'(out_valid), 64'd1);
            if (stop_mem40 && out_valid && out_kind && out_index == 16'd40) begin
                cpu_we = 1'b0;
                return;
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = ($urandom_range(0, 2) != 0);
            endcase
            stalled = out_valid && !out_ready;
            held = beat;
            if (out_valid && out_ready) begin
                if (mode == 0) check("beat_cycle", 64'(cycles), 64'(1 + beats));
                check("beat", beat, exp_q[beats]);
                $display("beat %0d kind=%0d idx=%0d data=%h", beats, out_kind, out_index, out_data);
                beats++;
            end
        end
        cpu_we = 1'b0;
        check("beat_count", 64'(beats), 64'(NBEATS));
        @(negedge clk);
        check("done_hi", 64'(done), 64'd1);
        check("valid_end", 64'(out_valid), 64'd0);
        check("freeze_end", 64'(freeze), 64'd1);
        repeat (3) @(negedge clk);
        check("done_stays", 64'(done), 64'd1);
        check("no_extra_beat", 64'(out_valid), 64'd0);
    endtask

    task automatic preload(input bit rnd);
        for (int i = 0; i < NREG; i++) regs[i] = rnd ? $urandom : 32'(i * 3);
        for (int j = 0; j < NMEM; j++) mem[j] = rnd ? $urandom : 32'hA000_0000 + 32'(j);
    endtask

    initial begin
        preload(1'b0);
        do_reset();

        // Quiet idle period.
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check_idle_outputs("idle");
        end

        // Full dump with ready held high.
        preload(1'b0);
        do_dump(0, 1'b0);

        // Alternating backpressure.
        do_reset();
        preload(1'b0);
        out_ready = 1'b0;
        do_dump(1, 1'b0);

        // Reset in the middle of the memory walk, then restart.
        do_reset();
        preload(1'b1);
        do_dump(0, 1'b1);
        check("mid_at_mem40", {47'd0, out_kind, out_index}, {47'd0, 1'b1, 16'd40});
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle_outputs("mid_reset");
        repeat (3) begin
            @(negedge clk);
            check_idle_outputs("post_reset");
        end
        do_dump(2, 1'b0);

        // Reset and halt together: reset wins.
        @(negedge clk);
        reset = 1'b1;
        halt  = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        halt  = 1'b0;
        check_idle_outputs("rst_halt");
        @(negedge clk);
        check_idle_outputs("rst_halt_next");
        preload(1'b1);
        do_dump(2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
